// File: rtl/alu.sv
// Clocked 4-bit ALU. Operation decode is purely combinational and feeds a
// single result register. Undefined opcodes produce zero with no error flag.
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [7:0] sel,
    output logic [3:0] result
);

    typedef enum logic [7:0] {
        OpAdd     = 8'd0,
        OpSub     = 8'd1,
        OpMul     = 8'd2,
        OpDiv     = 8'd3,
        OpMod     = 8'd4,
        OpAnd     = 8'd5,
        OpOr      = 8'd6,
        OpXor     = 8'd7,
        OpNand    = 8'd8,
        OpNor     = 8'd9,
        OpXnor    = 8'd10,
        OpNot     = 8'd11,
        OpShl     = 8'd12,
        OpShr     = 8'd13,
        OpRol     = 8'd14,
        OpRor     = 8'd15,
        OpAsr     = 8'd16,
        OpInc     = 8'd17,
        OpDec     = 8'd18,
        OpEq      = 8'd19,
        OpLt      = 8'd20,
        OpGt      = 8'd21,
        OpMax     = 8'd22,
        OpMin     = 8'd23,
        OpAbsDiff = 8'd24
    } op_e;

    logic [3:0] result_d;
    logic [7:0] product;
    logic       a_gt_b;
    logic       a_lt_b;

    assign product = {4'b0000, a} * {4'b0000, b};
    assign a_gt_b  = (a > b);
    assign a_lt_b  = (a < b);

    // Decode the full 8-bit select; anything outside the table yields zero.
    always_comb begin
        result_d = 4'h0;
        case (sel)
            OpAdd:     result_d = a + b;
            OpSub:     result_d = a - b;
            OpMul:     result_d = product[3:0];
            OpDiv:     result_d = (b == 4'h0) ? 4'hF : (a / b);
            OpMod:     result_d = (b == 4'h0) ? a : (a % b);
            OpAnd:     result_d = a & b;
            OpOr:      result_d = a | b;
            OpXor:     result_d = a ^ b;
            OpNand:    result_d = ~(a & b);
            OpNor:     result_d = ~(a | b);
            OpXnor:    result_d = ~(a ^ b);
            OpNot:     result_d = ~a;
            OpShl:     result_d = {a[2:0], 1'b0};
            OpShr:     result_d = {1'b0, a[3:1]};
            OpRol:     result_d = {a[2:0], a[3]};
            OpRor:     result_d = {a[0], a[3:1]};
            OpAsr:     result_d = {a[3], a[3:1]};
            OpInc:     result_d = a + 4'h1;
            OpDec:     result_d = a - 4'h1;
            OpEq:      result_d = {3'b000, (a == b)};
            OpLt:      result_d = {3'b000, a_lt_b};
            OpGt:      result_d = {3'b000, a_gt_b};
            OpMax:     result_d = a_gt_b ? a : b;
            OpMin:     result_d = a_lt_b ? a : b;
            OpAbsDiff: result_d = a_gt_b ? (a - b) : (b - a);
            default:   result_d = 4'h0;
        endcase
    end

    // Result register; async reset discards any pending computation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= 4'h0;
        end else begin
            result <= result_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: integer reference model, per-cycle compare,
// hand-computed directed vectors, reset and mid-cycle stability checks.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] sel;
    logic [3:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;
    logic [3:0] model_q;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .sel    (sel),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic int ref_fn(int x, int y, int op);
        case (op)
            0:  return (x + y) % 16;
            1:  return (x - y + 16) % 16;
            2:  return (x * y) % 16;
            3:  return (y == 0) ? 15 : x / y;
            4:  return (y == 0) ? x : x % y;
            5:  return x & y;
            6:  return x | y;
            7:  return x ^ y;
            8:  return 15 - (x & y);
            9:  return 15 - (x | y);
            10: return 15 - (x ^ y);
            11: return 15 - x;
            12: return (x * 2) % 16;
            13: return x / 2;
            14: return (x * 2) % 16 + x / 8;
            15: return x / 2 + (x % 2) * 8;
            16: return x / 2 + ((x >= 8) ? 8 : 0);
            17: return (x + 1) % 16;
            18: return (x + 15) % 16;
            19: return (x == y) ? 1 : 0;
            20: return (x < y) ? 1 : 0;
            21: return (x > y) ? 1 : 0;
            22: return (x > y) ? x : y;
            23: return (x < y) ? x : y;
            24: return (x > y) ? x - y : y - x;
            default: return 0;
        endcase
    endfunction

    // Model register: sampled inputs before each edge, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_q <= 4'h0;
        else        model_q <= 4'(ref_fn(int'(a), int'(b), int'(sel)));
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: result=%h expected=%h (a=%h b=%h sel=%0d) t=%0t",
                     name, got, want, a, b, sel, $time);
        end
    endtask

    // Compare against the model on every falling edge, away from capture.
    always @(negedge clk) begin
        if (cmp_en) check("model", result, model_q);
    end

    // Drive one operation mid-low-phase and check the literal one edge later.
    task automatic apply(input logic [3:0] ta, input logic [3:0] tb_v, input logic [7:0] ts,
                         input logic [3:0] want, input string name);
        @(negedge clk);
        a = ta; b = tb_v; sel = ts;
        @(posedge clk);
        #1 check(name, result, want);
    endtask

    initial begin
        a = 4'h0; b = 4'h0; sel = 8'd0;
        rst_n = 1'b0;
        #1 check("reset_init", result, 4'h0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold_init", result, 4'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Reset asserted mid-cycle with a nonzero result.
        apply(4'h4, 4'h2, 8'd0, 4'h6, "pre_reset_add");
        #2 rst_n = 1'b0;
        #1 check("reset_immediate", result, 4'h0);
        repeat (2) begin
            @(posedge clk);
            #1 check("reset_held", result, 4'h0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Arithmetic, a=4 b=2.
        apply(4'h4, 4'h2, 8'd0,  4'h6, "add");
        apply(4'h4, 4'h2, 8'd1,  4'h2, "sub");
        apply(4'h4, 4'h2, 8'd2,  4'h8, "mul");
        apply(4'h4, 4'h2, 8'd3,  4'h2, "div");
        apply(4'h4, 4'h2, 8'd4,  4'h0, "mod");
        apply(4'h4, 4'h2, 8'd17, 4'h5, "inc");
        apply(4'h4, 4'h2, 8'd18, 4'h3, "dec");
        apply(4'h4, 4'h2, 8'd24, 4'h2, "absdiff");
        // Logic and shifts.
        apply(4'h4, 4'h2, 8'd5,  4'h0, "and");
        apply(4'h4, 4'h2, 8'd6,  4'h6, "or");
        apply(4'h4, 4'h2, 8'd7,  4'h6, "xor");
        apply(4'h4, 4'h2, 8'd8,  4'hF, "nand");
        apply(4'h4, 4'h2, 8'd9,  4'h9, "nor");
        apply(4'h4, 4'h2, 8'd10, 4'h9, "xnor");
        apply(4'h4, 4'h2, 8'd11, 4'hB, "not");
        apply(4'h4, 4'h2, 8'd12, 4'h8, "shl");
        apply(4'h4, 4'h2, 8'd13, 4'h2, "shr");
        apply(4'h4, 4'h2, 8'd14, 4'h8, "rol");
        apply(4'h4, 4'h2, 8'd15, 4'h2, "ror");
        apply(4'h4, 4'h2, 8'd16, 4'h2, "asr");
        apply(4'h9, 4'h2, 8'd16, 4'hC, "asr_neg");
        apply(4'h9, 4'h2, 8'd14, 4'h3, "rol_msb");
        // Compares.
        apply(4'h4, 4'h2, 8'd19, 4'h0, "eq");
        apply(4'h4, 4'h2, 8'd20, 4'h0, "lt");
        apply(4'h4, 4'h2, 8'd21, 4'h1, "gt");
        apply(4'h4, 4'h2, 8'd22, 4'h4, "max");
        apply(4'h4, 4'h2, 8'd23, 4'h2, "min");
        apply(4'h7, 4'h7, 8'd19, 4'h1, "eq_true");
        // Boundaries.
        apply(4'hF, 4'h1, 8'd0,  4'h0, "add_wrap");
        apply(4'hF, 4'h1, 8'd17, 4'h0, "inc_wrap");
        apply(4'h0, 4'h1, 8'd18, 4'hF, "dec_wrap");
        apply(4'h3, 4'h5, 8'd1,  4'hE, "sub_wrap");
        apply(4'hF, 4'hF, 8'd2,  4'h1, "mul_trunc");
        apply(4'h6, 4'h0, 8'd3,  4'hF, "div_by_zero");
        apply(4'h6, 4'h0, 8'd4,  4'h6, "mod_by_zero");
        // Undefined opcodes.
        apply(4'h4, 4'h2, 8'd25,  4'h0, "undef_25");
        apply(4'h4, 4'h2, 8'd128, 4'h0, "undef_128");
        apply(4'h4, 4'h2, 8'd255, 4'h0, "undef_255");
        apply(4'h4, 4'h2, 8'd129, 4'h0, "undef_alias_1");

        // Mid-cycle input changes must not disturb the held result.
        apply(4'h5, 4'h3, 8'd0, 4'h8, "stable_base");
        #2 a = 4'hF; b = 4'hF; sel = 8'd2;
        #1 check("stable_mid1", result, 4'h8);
        #1 sel = 8'd11;
        #2 check("stable_mid2", result, 4'h8);
        @(posedge clk);
        #1 check("stable_next_edge", result, 4'h0);

        // Randomized sweep, checked by the per-cycle compare process.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) sel = 8'($urandom_range(0, 255));
            else                          sel = 8'($urandom_range(0, 26));
        end
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
